thumb_inst_align: RTL

Thumb-2 instruction fetch/alignment unit: issues word-aligned fetch requests to instruction memory, buffers returned halfwords, and assembles 16- and 32-bit Thumb instructions. Each instruction is presented in the 32-bit left-aligned format the instruction pattern decoder consumes: the first halfword is in `inst[31:16]`. The unit sits between instruction memory and the decode stage, and also handles branch redirection (flush).

---
 rtl/thumb_inst_align_pkg.sv | 27 ++
 rtl/thumb_inst_align_hw_fifo4.sv | 50 +++++
 rtl/thumb_inst_align.sv | 104 ++++++++++
 3 files changed

// File: rtl/thumb_inst_align_pkg.sv
// Shared Thumb-2 fetch definitions: halfword width, 32-bit instruction prefixes and
// the left-aligned instruction format the pattern decoder consumes.
package thumb_inst_align_pkg;

  localparam int HW_W = 16;

  // hw0[15:11] values that announce a 32-bit Thumb-2 encoding
  localparam logic [4:0] PFX32_A = 5'b11101;
  localparam logic [4:0] PFX32_B = 5'b11110;
  localparam logic [4:0] PFX32_C = 5'b11111;

  function automatic logic is_32bit(input logic [HW_W-1:0] hw);
    logic [4:0] pfx;
    pfx = hw[HW_W-1 -: 5];
    return (pfx == PFX32_A) || (pfx == PFX32_B) || (pfx == PFX32_C);
  endfunction

  // First halfword always lands in [31:16]; a 16-bit instruction zero-fills [15:0].
  function automatic logic [2*HW_W-1:0] left_align(
    input logic [HW_W-1:0] hw0,
    input logic [HW_W-1:0] hw1,
    input logic            wide
  );
    return wide ? {hw0, hw1} : {hw0, {HW_W{1'b0}}};
  endfunction

endpackage

// File: rtl/thumb_inst_align_hw_fifo4.sv
// Halfword FIFO: push 0/1/2, pop 0/1/2 and clear in one cycle; head and next entry
// are exposed directly so a 32-bit instruction can be assembled without a read port.
module hw_fifo4
  import thumb_inst_align_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic [1:0]      push_n,
  input  logic [HW_W-1:0] push_d0,
  input  logic [HW_W-1:0] push_d1,
  input  logic [1:0]      pop_n,
  output logic [HW_W-1:0] hd0,
  output logic [HW_W-1:0] hd1,
  output logic [CW-1:0]   count
);

  logic [DEPTH-1:0][HW_W-1:0] mem_q;
  logic [DEPTH-1:0][HW_W-1:0] mem_d;
  logic [DEPTH-1:0][HW_W-1:0] shifted;
  logic [CW-1:0]              base;

  // Entry 0 is the head: popping shifts the array down, pushes land after the survivors.
  always_comb begin
    shifted = mem_q >> (HW_W * int'(pop_n));
    base    = count - CW'(pop_n);
    mem_d   = shifted;
    for (int i = 0; i < DEPTH; i++) begin
      if (push_n != 2'd0 && CW'(i) == base)           mem_d[i] = push_d0;
      if (push_n == 2'd2 && CW'(i) == base + CW'(1))  mem_d[i] = push_d1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      count <= '0;
    end else begin
      mem_q <= mem_d;
      count <= clr ? '0 : count + CW'(push_n) - CW'(pop_n);
    end
  end

  assign hd0 = mem_q[0];
  assign hd1 = mem_q[1];

endmodule

// File: rtl/thumb_inst_align.sv
// Thumb-2 fetch/align: word fetches with one request in flight, halfword buffering,
// 16/32-bit instruction assembly and branch flush with stale-response dropping.
module thumb_inst_align
  import thumb_inst_align_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BUF_HW   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic        inst_is32,
  output logic [31:0] inst_pc
);

  localparam int            CW      = $clog2(BUF_HW + 1);
  // A fresh word must always fit: request only while two slots are free.
  localparam logic [CW-1:0] REQ_MAX = CW'(BUF_HW - 2);

  logic [CW-1:0]   count;
  logic [HW_W-1:0] hd0, hd1, push_d0;
  logic [1:0]      push_n, pop_n;
  logic [31:0]     addr_q, pc_q;
  logic            outstanding, drop_rsp, skip_lo;
  logic            wide, req_fire, inst_fire, rsp_take;
  logic            unused_tgt;

  assign unused_tgt = branch_target[0];

  assign wide       = is_32bit(hd0);
  assign inst_valid = !branch_valid &&
                      ((count >= CW'(2)) || (count == CW'(1) && !wide));
  assign inst       = left_align(hd0, hd1, wide);
  assign inst_is32  = wide;
  assign inst_pc    = pc_q;
  assign req_addr   = addr_q;
  assign req_valid  = rst_n && !outstanding && (count <= REQ_MAX);

  assign req_fire  = req_valid && req_ready;
  assign inst_fire = inst_valid && inst_ready;
  assign rsp_take  = rsp_valid && !drop_rsp && !branch_valid;

  assign pop_n   = inst_fire ? (wide ? 2'd2 : 2'd1) : 2'd0;
  assign push_n  = rsp_take ? (skip_lo ? 2'd1 : 2'd2) : 2'd0;
  assign push_d0 = skip_lo ? rsp_data[31:16] : rsp_data[15:0];

  hw_fifo4 #(.DEPTH(BUF_HW)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (branch_valid),
    .push_n  (push_n),
    .push_d0 (push_d0),
    .push_d1 (rsp_data[31:16]),
    .pop_n   (pop_n),
    .hd0     (hd0),
    .hd1     (hd1),
    .count   (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= {RESET_PC[31:2], 2'b00};
      pc_q        <= {RESET_PC[31:1], 1'b0};
      outstanding <= 1'b0;
      drop_rsp    <= 1'b0;
      skip_lo     <= RESET_PC[1];
    end else if (branch_valid) begin
      addr_q  <= {branch_target[31:2], 2'b00};
      pc_q    <= {branch_target[31:1], 1'b0};
      skip_lo <= branch_target[1];
      // Anything in flight belongs to the old stream and must be swallowed.
      if (req_fire) begin
        outstanding <= 1'b1;
        drop_rsp    <= 1'b1;
      end else if (outstanding && !rsp_valid) begin
        drop_rsp <= 1'b1;
      end else begin
        outstanding <= 1'b0;
        drop_rsp    <= 1'b0;
      end
    end else begin
      if (rsp_valid) begin
        outstanding <= 1'b0;
        drop_rsp    <= 1'b0;
        if (!drop_rsp) skip_lo <= 1'b0;
      end
      if (req_fire) begin
        outstanding <= 1'b1;
        addr_q      <= addr_q + 32'd4;
      end
      if (inst_fire) pc_q <= pc_q + (wide ? 32'd4 : 32'd2);
    end
  end

endmodule
